// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: pipelined multiplier, radix-2^DIV_BITS restoring divider.
// Holds the pipeline while busy and returns a single writeback strobe.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic            valid_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int DIV_ITERS = XLEN / DIV_BITS;
    localparam int CW        = $clog2(DIV_ITERS);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_nx;

    logic            accept, div_sgn, div_zero, div_ovf;
    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] abs1, abs2;

    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            qneg_q, rneg_q;

    logic [XLEN-1:0] quo_nx, rem_nx;
    logic [XLEN:0]   part, diff;
    logic            ge;

    logic [2*XLEN-1:0] prod_now, mul_res;
    logic              mul_last;

    logic [XLEN-1:0] res_d, quo_fix, rem_fix;
    logic [4:0]      rd_d;

    assign accept   = (state == S_IDLE) && start_i && !flush_i;
    assign div_sgn  = !funct3_i[0];
    assign div_zero = (op2_i == '0);
    assign div_ovf  = div_sgn && (op1_i == MIN_NEG) && (&op2_i);
    assign abs1     = (div_sgn && op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign abs2     = (div_sgn && op2_i[XLEN-1]) ? -op2_i : op2_i;

    // MULH: s x s, MULHSU: s x u, MUL/MULHU: u x u. Low 2*XLEN bits of the
    // extended product are the exact signed/unsigned product.
    assign a_sgn    = funct3_i[1] ^ funct3_i[0];
    assign b_sgn    = !funct3_i[1] && funct3_i[0];
    assign prod_now = {{XLEN{a_sgn && op1_i[XLEN-1]}}, op1_i}
                    * {{XLEN{b_sgn && op2_i[XLEN-1]}}, op2_i};

    generate
        if (MUL_CYCLES == 1) begin : g_mul_comb
            assign mul_last = 1'b0;
            assign mul_res  = prod_now;
        end else begin : g_mul_pipe
            // The output register is the last stage, so MUL_CYCLES-1 stages live here.
            logic                                   mul_go;
            logic [MUL_CYCLES-2:0]                  vld_pipe;
            logic [MUL_CYCLES-2:0][2*XLEN-1:0]      prod_pipe;

            assign mul_go = accept && !funct3_i[2];

            always_ff @(posedge clk) begin
                if (!rst_n || flush_i) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= mul_go;
                    for (int k = 1; k < MUL_CYCLES - 1; k++) vld_pipe[k] <= vld_pipe[k-1];
                end
            end

            always_ff @(posedge clk) begin
                prod_pipe[0] <= prod_now;
                for (int k = 1; k < MUL_CYCLES - 1; k++) prod_pipe[k] <= prod_pipe[k-1];
            end

            assign mul_last = vld_pipe[MUL_CYCLES-2];
            assign mul_res  = prod_pipe[MUL_CYCLES-2];
        end
    endgenerate

    // DIV_BITS restoring steps unrolled per cycle; rem < divisor keeps part within XLEN+1 bits.
    always_comb begin
        quo_nx = quo_q;
        rem_nx = rem_q;
        part   = '0;
        diff   = '0;
        ge     = 1'b0;
        for (int i = 0; i < DIV_BITS; i++) begin
            part   = {rem_nx, quo_nx[XLEN-1]};
            diff   = part - {1'b0, dvs_q};
            ge     = (part >= {1'b0, dvs_q});
            quo_nx = {quo_nx[XLEN-2:0], ge};
            rem_nx = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
        end
    end

    assign quo_fix = qneg_q ? -quo_q : quo_q;
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    always_comb begin
        state_nx = state;
        res_d    = '0;
        rd_d     = rd_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    rd_d = rd_addr_i;
                    if (!funct3_i[2]) begin
                        if (MUL_CYCLES == 1) begin
                            state_nx = S_DONE;
                            res_d    = (funct3_i[1:0] == 2'b00) ? mul_res[XLEN-1:0]
                                                                : mul_res[2*XLEN-1:XLEN];
                        end else begin
                            state_nx = S_MUL;
                        end
                    end else if (div_zero) begin
                        state_nx = S_DONE;
                        res_d    = funct3_i[1] ? op1_i : '1;
                    end else if (div_ovf) begin
                        state_nx = S_DONE;
                        res_d    = funct3_i[1] ? '0 : op1_i;
                    end else begin
                        state_nx = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_nx = S_IDLE;
                end else if (mul_last) begin
                    state_nx = S_DONE;
                    res_d    = (f3_q[1:0] == 2'b00) ? mul_res[XLEN-1:0]
                                                    : mul_res[2*XLEN-1:XLEN];
                end
            end
            S_DIV: begin
                if (flush_i)            state_nx = S_IDLE;
                else if (cnt_q == '0)   state_nx = S_FIX;
            end
            S_FIX: begin
                if (flush_i) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_DONE;
                    res_d    = f3_q[1] ? rem_fix : quo_fix;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_data_o <= '0;
            rd_addr_o <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == S_DONE) begin
                rd_data_o <= res_d;
                rd_addr_o <= rd_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q   <= funct3_i;
            rd_q   <= rd_addr_i;
            quo_q  <= abs1;
            rem_q  <= '0;
            dvs_q  <= abs2;
            cnt_q  <= CW'(DIV_ITERS - 1);
            qneg_q <= div_sgn && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
            rneg_q <= div_sgn && op1_i[XLEN-1];
        end else if (state == S_DIV) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Dropping hold in DONE lets the pipeline advance alongside writeback.
    assign hold_flag_o = !flush_i && (((state == S_IDLE) && start_i)
                         || (state == S_MUL) || (state == S_DIV) || (state == S_FIX));
    assign valid_o     = (state == S_DONE);
    assign rd_wen_o    = valid_o;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    localparam int XLEN    = 32;
    localparam int MC      = 2;
    localparam int DB      = 1;
    localparam int DIV_LAT = XLEN / DB + 2;
    localparam int LAT_MAX = 100;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        hold_flag_o, valid_o, rd_wen_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(XLEN), .MUL_CYCLES(MC), .DIV_BITS(DB)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .hold_flag_o(hold_flag_o), .valid_o(valid_o), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        p  = '0;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = 64'(longint'(sa) * longint'(sb)); return p[63:32]; end
            3'd2: begin p = 64'(longint'(sa) * longint'({32'h0, b})); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : (a == MIN && b == '1) ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : (a == MIN && b == '1) ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MC;
        if (b == 0) return 1;
        if (!f[0] && a == MIN && b == '1) return 1;
        return DIV_LAT;
    endfunction

    // One op from start to writeback; inj > 0 presents a competing start in that busy cycle.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string tag, input int inj);
        int lat;
        bit hold_ok;
        logic [31:0] d;
        logic [4:0] ra;
        logic wen;
        lat = 0; d = '0; ra = '0; wen = 1'b0;
        @(negedge clk);
        funct3_i = f; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        #1;
        hold_ok = hold_flag_o;
        chk({tag, "/idle_vld"}, valid_o, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0; funct3_i = 3'($urandom); op1_i = $urandom; op2_i = $urandom;
        rd_addr_i = 5'($urandom);
        for (int c = 1; c <= LAT_MAX; c++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = c; d = rd_data_o; ra = rd_addr_o; wen = rd_wen_o;
                hold_ok &= !hold_flag_o;
                break;
            end
            hold_ok &= hold_flag_o;
            if (c == inj) begin
                start_i = 1'b1; funct3_i = 3'd0; op1_i = 32'd2; op2_i = 32'd3; rd_addr_i = ~rd;
            end
            if (c == inj + 1) start_i = 1'b0;
        end
        chk({tag, "/lat"},  lat, ref_lat(f, a, b));
        chk({tag, "/data"}, d,   ref_res(f, a, b));
        chk({tag, "/addr"}, ra,  rd);
        chk({tag, "/wen"},  wen, 1);
        chk({tag, "/hold"}, hold_ok, 1);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          seen;

        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/vld",  valid_o,     0);
        chk("rst/wen",  rd_wen_o,    0);
        chk("rst/data", rd_data_o,   0);
        chk("rst/addr", rd_addr_o,   0);
        chk("rst/hold", hold_flag_o, 0);
        rst_n = 1'b1;

        do_op(3'd0, 32'd7,  32'hFFFF_FFFD, 5'd1, "mul",    0);
        do_op(3'd1, MIN,    32'hFFFF_FFFF, 5'd2, "mulh",   0);
        do_op(3'd2, MIN,    32'hFFFF_FFFF, 5'd3, "mulhsu", 0);
        do_op(3'd3, MIN,    32'hFFFF_FFFF, 5'd4, "mulhu",  0);
        do_op(3'd4, -32'd20, 32'd3,        5'd5, "div",    0);
        do_op(3'd6, -32'd20, 32'd3,        5'd6, "rem",    0);
        do_op(3'd5, 32'd5,  32'd0,         5'd7, "divu0",  0);
        do_op(3'd7, 32'd5,  32'd0,         5'd8, "remu0",  0);
        do_op(3'd4, 32'd9,  32'd0,         5'd9, "div0",   0);
        do_op(3'd4, MIN,    32'hFFFF_FFFF, 5'd10, "ovf_div", 0);
        do_op(3'd6, MIN,    32'hFFFF_FFFF, 5'd11, "ovf_rem", 0);
        do_op(3'd5, MIN,    32'hFFFF_FFFF, 5'd12, "divu_big", 0);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = MIN; b = '1; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                3: a = ~32'($urandom_range(0, 999));
                4: b = ~32'($urandom_range(0, 15));
                default: ;
            endcase
            do_op(f, a, b, 5'($urandom_range(1, 31)), $sformatf("rnd%0d", i), 0);
        end

        // Flush a long divide in cycle 10, then start a multiply right away.
        @(negedge clk);
        funct3_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd13; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            seen |= valid_o;
        end
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        seen |= valid_o;
        chk("flush/hold", hold_flag_o, 0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        chk("flush/idle_hold", hold_flag_o, 0);
        chk("flush/no_vld", seen, 0);
        do_op(3'd0, 32'd3, 32'd4, 5'd14, "post_flush", 0);

        // A start while busy must be ignored.
        do_op(3'd5, 32'd100, 32'd9, 5'd5, "busy", 3);

        // Reset in cycle 5 of a divide.
        @(negedge clk);
        funct3_i = 3'd4; op1_i = -32'd100; op2_i = 32'd7; rd_addr_i = 5'd17; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (4) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst/vld",  valid_o,     0);
        chk("mrst/data", rd_data_o,   0);
        chk("mrst/addr", rd_addr_o,   0);
        chk("mrst/hold", hold_flag_o, 0);
        seen = 1'b0;
        for (int c = 0; c < DIV_LAT + 6; c++) begin
            @(negedge clk);
            seen |= valid_o;
        end
        chk("mrst/no_vld", seen, 0);
        do_op(3'd6, 32'd77, 32'd10, 5'd21, "post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
